// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The request side holds req/addr steady until a same-cycle ack with rdata.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps one imem request in flight, buffers a response
// in a skid register when decode stalls, and drains in-flight requests after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic [31:0]        pcplus4,
  output logic [31:0]        instruction,
  output logic               valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL, S_DRAIN} state_t;

  state_t      state_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic [31:0] pc_q;
  logic [31:0] skid_q;
  logic [31:0] skid_pc4_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pcplus4_q;

  logic [31:0] pc_next;
  logic [31:0] redir_pc;
  logic        accept;
  logic        unused_redirect_lsbs;

  assign pc_next              = pc_q + 32'd4;
  assign redir_pc             = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  // An ack only counts while a request is actually being driven.
  assign accept               = imem_req_q & imem.imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      pc_q        <= RESET_PC;
      skid_q      <= 32'h0;
      skid_pc4_q  <= 32'h0;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pcplus4_q   <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          imem_req_q <= 1'b1;
          state_q    <= S_REQ;
          if (redirect) begin
            pc_q        <= redir_pc;
            imem_addr_q <= redir_pc;
          end else begin
            imem_addr_q <= pc_q;
          end
        end

        S_REQ: begin
          if (redirect) begin
            pc_q    <= redir_pc;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            // Without an ack the old request must finish before the new one starts.
            if (accept) imem_addr_q <= redir_pc;
            else        state_q     <= S_DRAIN;
          end else if (accept) begin
            pc_q        <= pc_next;
            imem_addr_q <= pc_next;
            if (stall && valid_q) begin
              skid_q     <= imem.imem_rdata;
              skid_pc4_q <= pc_next;
              imem_req_q <= 1'b0;
              state_q    <= S_FULL;
            end else begin
              instr_q   <= imem.imem_rdata;
              pcplus4_q <= pc_next;
              valid_q   <= 1'b1;
            end
          end else if (!stall) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
          end
        end

        S_FULL: begin
          if (redirect) begin
            skid_q      <= 32'h0;
            skid_pc4_q  <= 32'h0;
            pc_q        <= redir_pc;
            imem_addr_q <= redir_pc;
            imem_req_q  <= 1'b1;
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            state_q     <= S_REQ;
          end else if (!stall) begin
            instr_q     <= skid_q;
            pcplus4_q   <= skid_pc4_q;
            valid_q     <= 1'b1;
            imem_addr_q <= pc_q;
            imem_req_q  <= 1'b1;
            state_q     <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (redirect) pc_q <= redir_pc;
          if (accept) begin
            imem_addr_q <= redirect ? redir_pc : pc_q;
            state_q     <= S_REQ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign valid          = valid_q;
  assign instruction    = instr_q;
  assign pcplus4        = pcplus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a transaction-level model
// built from an address stream, a one-deep skid queue and a drain flag.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pcplus4;
  logic [31:0] instruction;
  logic        valid;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .pcplus4     (pcplus4),
    .instruction (instruction),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: what the fetch stage must look like after each clock.
  bit          m_started;
  bit          m_req;
  bit          m_discard;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [63:0] m_skid[$];
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_req = 0; m_discard = 0;
    m_addr = 32'h0; m_pc = 32'h0; m_skid.delete();
    m_valid = 0; m_instr = NOP; m_pc4 = 32'h0;
  endtask

  task automatic model_kill();
    m_valid = 0;
    m_instr = NOP;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit ak, input logic [31:0] rdata);
    logic [31:0] ra;
    bit taken;
    ra    = rpc & 32'hFFFF_FFFC;
    taken = m_req && ak;
    if (!m_started) begin
      m_started = 1;
      if (rd) m_pc = ra;
      m_req  = 1;
      m_addr = m_pc;
    end else if (m_discard) begin
      if (rd) m_pc = ra;
      if (taken) begin
        m_discard = 0;
        m_addr    = m_pc;
      end
    end else if (m_skid.size() != 0) begin
      if (rd) begin
        m_skid.delete();
        m_pc = ra;
        model_kill();
        m_req = 1; m_addr = m_pc;
      end else if (!st) begin
        {m_instr, m_pc4} = m_skid.pop_front();
        m_valid = 1;
        m_req = 1; m_addr = m_pc;
      end
    end else if (rd) begin
      m_pc = ra;
      model_kill();
      if (taken) m_addr = m_pc;
      else       m_discard = 1;
    end else if (taken) begin
      if (st && m_valid) begin
        m_skid.push_back({rdata, m_pc + 32'd4});
        m_req = 0;
      end else begin
        m_valid = 1; m_instr = rdata; m_pc4 = m_pc + 32'd4;
      end
      m_pc   = m_pc + 32'd4;
      m_addr = m_pc;
    end else if (!st) begin
      model_kill();
    end
  endtask

  task automatic compare_all();
    check("valid", {31'h0, valid}, {31'h0, m_valid});
    check("instruction", instruction, m_instr);
    check("pcplus4", pcplus4, m_pc4);
    check("imem_req", {31'h0, imem_bus.imem_req}, {31'h0, m_req});
    if (m_req) check("imem_addr", imem_bus.imem_addr, m_addr);
    if (valid) check("stream", instruction, mem(pcplus4 - 32'd4));
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock, compare.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit ak);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_bus.imem_ack   = ak;
    imem_bus.imem_rdata = mem(imem_bus.imem_addr);
    model_step(st, rd, rpc, ak, imem_bus.imem_rdata);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc4", pcplus4, 32'h0);
    check("rst_addr", imem_bus.imem_addr, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    cycle(0, 0, 0, 0);
    check("first_req", {31'h0, imem_bus.imem_req}, 32'h1);
    check("first_addr", imem_bus.imem_addr, 32'h0);

    // Zero-wait stream
    cycle(0, 0, 0, 1);
    check("zw_A", instruction, 32'hC0DE_0000); check("zw_A_pc4", pcplus4, 32'h4);
    cycle(0, 0, 0, 1);
    check("zw_B", instruction, 32'hC0DE_0004); check("zw_B_pc4", pcplus4, 32'h8);
    cycle(0, 0, 0, 1);
    check("zw_C", instruction, 32'hC0DE_0008); check("zw_C_pc4", pcplus4, 32'hC);
    cycle(0, 0, 0, 1);

    // Wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      check("ws_addr", imem_bus.imem_addr, 32'h10);
      check("ws_instr", instruction, NOP);
    end
    cycle(0, 0, 0, 1);
    check("ws_data", instruction, 32'hC0DE_0010); check("ws_pc4", pcplus4, 32'h14);

    // Skid: stall while ack arrives
    cycle(1, 0, 0, 1);
    check("skid_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("skid_hold", instruction, 32'hC0DE_0010);
    cycle(1, 0, 0, 1);
    check("skid_hold2", pcplus4, 32'h14);
    cycle(0, 0, 0, 0);
    check("skid_out", instruction, 32'hC0DE_0014); check("skid_pc4", pcplus4, 32'h18);
    check("skid_next_addr", imem_bus.imem_addr, 32'h18);

    // Redirect while request at 0x18 is unacked
    cycle(0, 1, 32'h100, 0);
    check("rd_addr_hold", imem_bus.imem_addr, 32'h18);
    check("rd_valid", {31'h0, valid}, 32'h0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("rd_dropped", instruction, NOP);
    check("rd_new_addr", imem_bus.imem_addr, 32'h100);
    cycle(0, 0, 0, 1);
    check("rd_data", instruction, 32'hC0DE_0100); check("rd_pc4", pcplus4, 32'h104);

    // Wraparound, redirect low bits ignored
    cycle(0, 1, 32'hFFFF_FFFE, 1);
    check("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    check("wrap_pc4", pcplus4, 32'h0);
    check("wrap_next", imem_bus.imem_addr, 32'h0);

    // Asynchronous reset while the skid holds an instruction
    cycle(1, 0, 0, 1);
    check("full_req", {31'h0, imem_bus.imem_req}, 32'h0);
    cycle(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("ar_valid", {31'h0, valid}, 32'h0);
    check("ar_instr", instruction, NOP);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("ar_first", instruction, 32'hC0DE_0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom % 100) < 30, ($urandom % 100) < 8, $urandom, ($urandom % 100) < 60);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
